// File: rtl/pipe_mult_fx.sv
// Pipelined fixed-point multiplier: full product, round-to-nearest (ties up), saturate.
// Elastic valid/ready pipeline of LAT stages with bubble collapsing.
module pipe_mult_fx #(
    parameter int unsigned W      = 24,
    parameter int unsigned FRAC   = 12,
    parameter int unsigned LAT    = 3,
    parameter bit          SIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic         overflow
);

    // Two guard bits keep the rounding add and unsigned products free of wrap.
    localparam int unsigned PW = 2 * W + 2;
    localparam logic signed [PW-1:0] ONE  = PW'(1);
    localparam logic signed [PW-1:0] RND  = (ONE <<< FRAC) >>> 1;
    localparam logic signed [PW-1:0] MAXV = SIGNED ? (ONE <<< (W - 1)) - ONE : (ONE <<< W) - ONE;
    localparam logic signed [PW-1:0] MINV = SIGNED ? -(ONE <<< (W - 1)) : PW'(0);

    logic [LAT-1:0]          r_vld;
    logic [LAT-1:0]          w_load;
    logic signed [PW-1:0]    w_a_ext;
    logic signed [PW-1:0]    w_b_ext;
    logic signed [PW-1:0]    w_prod;

    function automatic logic [W:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        r = (p + RND) >>> FRAC;
        if (r > MAXV) begin
            return {1'b1, MAXV[W-1:0]};
        end else if (r < MINV) begin
            return {1'b1, MINV[W-1:0]};
        end
        return {1'b0, r[W-1:0]};
    endfunction

    always_comb begin
        w_a_ext = PW'(0);
        w_b_ext = PW'(0);
        if (SIGNED) begin
            w_a_ext = PW'($signed(a));
            w_b_ext = PW'($signed(b));
        end else begin
            w_a_ext = PW'(a);
            w_b_ext = PW'(b);
        end
        w_prod = w_a_ext * w_b_ext;
    end

    // A stage can load when it or any stage downstream of it has room, or the output drains.
    always_comb begin
        w_load = '0;
        for (int unsigned k = 0; k < LAT; k++) begin
            w_load[k] = out_ready;
            for (int unsigned j = k; j < LAT; j++) begin
                if (!r_vld[j]) begin
                    w_load[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            if (w_load[0]) begin
                r_vld[0] <= in_valid;
            end
            for (int unsigned k = 1; k < LAT; k++) begin
                if (w_load[k]) begin
                    r_vld[k] <= r_vld[k-1];
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_vld[LAT-1];

    generate
        if (LAT == 1) begin : g_lat1
            logic [W:0] r_res;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_res <= '0;
                end else if (w_load[0] && in_valid) begin
                    r_res <= round_sat(w_prod);
                end
            end

            assign c        = r_res[W-1:0];
            assign overflow = r_res[W];
        end else begin : g_latn
            // Stage 1 holds the raw product; stage 2 rounds and saturates; later stages carry.
            logic signed [PW-1:0] r_prod;
            logic [W:0]           r_res [LAT-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_prod <= '0;
                    for (int unsigned j = 0; j < LAT - 1; j++) begin
                        r_res[j] <= '0;
                    end
                end else begin
                    if (w_load[0] && in_valid) begin
                        r_prod <= w_prod;
                    end
                    if (w_load[1] && r_vld[0]) begin
                        r_res[0] <= round_sat(r_prod);
                    end
                    for (int unsigned j = 1; j < LAT - 1; j++) begin
                        if (w_load[j+1] && r_vld[j]) begin
                            r_res[j] <= r_res[j-1];
                        end
                    end
                end
            end

            assign c        = r_res[LAT-2][W-1:0];
            assign overflow = r_res[LAT-2][W];
        end
    endgenerate

endmodule

// File: tb/tb_pipe_mult_fx.sv
// Self-checking bench for pipe_mult_fx: directed vectors plus randomized traffic
// scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pipe_mult_fx;

    localparam int W    = 24;
    localparam int FRAC = 12;
    localparam int LAT  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic         overflow;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int xfer_cnt = 0;
    bit lat_chk  = 1'b0;

    logic [W:0] exp_q[$];
    int         acc_cyc_q[$];
    logic       hold_prev = 1'b0;
    logic [W:0] held;
    logic [W:0] mon_e;
    int         mon_ac;

    pipe_mult_fx dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact signed product, add half an LSB, floor-shift, clamp.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        longint p, r, mx, mn, rnd;
        p   = longint'($signed(x)) * longint'($signed(y));
        rnd = longint'(1) <<< (FRAC - 1);
        r   = (p + rnd) >>> FRAC;
        mx  = (longint'(1) <<< (W - 1)) - 1;
        mn  = -(longint'(1) <<< (W - 1));
        if (r > mx) return {1'b1, mx[W-1:0]};
        if (r < mn) return {1'b1, mn[W-1:0]};
        return {1'b0, r[W-1:0]};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 24'h7FFFFF;
            1:       return 24'h800000;
            2:       return W'($urandom_range(0, 8191));
            3:       return 24'hFFF000 ^ W'($urandom_range(0, 4095));
            default: return W'($urandom);
        endcase
    endfunction

    // Scoreboard: handshakes are decided by values stable at the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_prev) chk("hold_stable", {overflow, c}, held);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b));
                acc_cyc_q.push_back(cyc + 1);
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                chk("queue_nonempty", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e  = exp_q.pop_front();
                    mon_ac = acc_cyc_q.pop_front();
                    chk("result", {overflow, c}, mon_e);
                    if (lat_chk) chk("latency", 64'(cyc + 1 - mon_ac), LAT);
                end
            end
            hold_prev = out_valid && !out_ready;
            held      = {overflow, c};
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W:0] e);
        int n;
        bit seen;
        step();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        chk("one_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        n    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                n    = i;
            end
        end
        chk("one_latency", n, LAT);
        chk("one_value", {overflow, c}, e);
    endtask

    task automatic drain();
        int i;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        i = 0;
        while (exp_q.size() != 0 && i < 50) begin
            step();
            i++;
        end
        step();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int a0, x0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_overflow", overflow, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        // Directed arithmetic vectors with expected values stated in fixed-point terms.
        lat_chk = 1'b1;
        run_one(24'h001000, 24'h002000, {1'b0, 24'h002000});
        run_one(24'hFFF000, 24'h003000, {1'b0, 24'hFFD000});
        run_one(24'h000001, 24'h000800, {1'b0, 24'h000001});
        run_one(24'h7FFFFF, 24'h7FFFFF, {1'b1, 24'h7FFFFF});
        run_one(24'h800000, 24'h7FFFFF, {1'b1, 24'h800000});
        drain();

        // Back-to-back stream: one result per cycle at fixed latency.
        step();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a0 = acc_cnt;
        x0 = xfer_cnt;
        repeat (20) begin
            a = pick();
            b = pick();
            step();
        end
        in_valid = 1'b0;
        chk("stream_acc", acc_cnt - a0, 20);
        drain();
        chk("stream_xfer", xfer_cnt - x0, 20);

        // Backpressure: fill, stall, then release with input still offered.
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a0 = acc_cnt;
        repeat (8) begin
            a = pick();
            b = pick();
            step();
        end
        chk("bp_accepted", acc_cnt - a0, LAT);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        step();
        out_ready = 1'b1;
        a0 = acc_cnt;
        x0 = xfer_cnt;
        repeat (6) begin
            step();
            a = pick();
            b = pick();
        end
        chk("bp_release_xfer", xfer_cnt - x0, 6);
        chk("bp_release_acc", acc_cnt - a0, 6);
        drain();

        // Bubble collapse: only the last stage is occupied and stalled.
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = pick();
        b = pick();
        step();
        in_valid = 1'b0;
        repeat (LAT) step();
        in_valid = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            a = pick();
            b = pick();
            @(negedge clk);
            chk("bubble_in_ready", in_ready, 64'(i < LAT - 1));
            step();
        end
        drain();

        // Reset with two pairs in flight, oldest already presented.
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = pick();
        b = pick();
        step();
        a = pick();
        b = pick();
        step();
        in_valid = 1'b0;
        repeat (LAT) step();
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_c", c, 0);
        chk("mid_rst_overflow", overflow, 0);
        exp_q.delete();
        acc_cyc_q.delete();
        step();
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        x0 = xfer_cnt;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        repeat (10) step();
        chk("post_rst_no_result", xfer_cnt - x0, 0);

        // Randomized traffic with random backpressure.
        repeat (500) begin
            step();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            a = pick();
            b = pick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/pipe_mult_fx.md
PIPE_MULT_FX -- requirements
Module: pipe_mult_fx

Interface
REQ-001 SHALL have parameter W, default 24: operand and result width in bits.
REQ-002 SHALL have parameter FRAC, default 12: fractional bits of both operands and result; legal range 0 <= FRAC < W.
REQ-003 SHALL have parameter LAT, default 3: pipeline depth in stages; legal range LAT >= 1.
REQ-004 SHALL have parameter SIGNED, default 1: 1 selects two's-complement operands and result, 0 selects unsigned.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: a and b carry an operand pair.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-009 SHALL have ports a and b, inputs, W bits each: fixed-point operands.
REQ-010 SHALL have port out_valid, output, 1 bit: c and overflow hold a result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 SHALL have port c, output, W bits: fixed-point result.
REQ-013 SHALL have port overflow, output, 1 bit: c was saturated; meaningful only while out_valid=1.

Function
REQ-014 SHALL accept a pair on a rising edge where in_valid=1 and in_ready=1, and take nothing otherwise.
REQ-015 SHALL transfer a result on a rising edge where out_valid=1 and out_ready=1.
REQ-016 SHALL compute the full 2W-bit product a*b, signed or unsigned per SIGNED.
REQ-017 SHALL round to nearest with ties toward +infinity: add 2^(FRAC-1) to the product (no addition when FRAC=0), then shift arithmetically right by FRAC.
REQ-018 SHALL saturate the shifted value to W bits: signed range [-2^(W-1), 2^(W-1)-1], unsigned range [0, 2^W-1]; overflow=1 exactly when clamping occurred.
REQ-019 SHALL hold one valid bit per stage k=1..LAT; stage LAT drives out_valid, c and overflow.
REQ-020 SHALL load stage k when it is empty or its contents advance this cycle; stage LAT advances when out_ready=1; in_ready = stage-1 load condition.
REQ-021 SHALL collapse bubbles: an empty stage accepts from the previous stage even while downstream stages are stalled.
REQ-022 SHALL, when out_ready is held at 1, present a pair accepted at edge N as out_valid=1 with its result after edge N+LAT-1, so it transfers at edge N+LAT, sustaining one result per cycle.
REQ-023 SHALL hold at most LAT pairs in flight; with out_ready=0 and in_valid=1, in_ready SHALL fall once all LAT stages are full.
REQ-024 SHALL, when full with out_ready=1 and in_valid=1, accept the new pair and emit the oldest result on the same edge (no throughput loss).
REQ-025 SHALL keep c and overflow stable while out_valid=1 and out_ready=0.
REQ-026 SHALL deliver results in acceptance order, with no loss or duplication.
REQ-027 SHALL have no combinational path from a or b to any output; in_ready MAY depend combinationally on out_ready.

Reset
REQ-028 SHALL, while rst=1, immediately clear all stage valid bits and drive out_valid=0, c=0 and overflow=0, with in_ready=1 after release.
REQ-029 SHALL discard all in-flight pairs when reset is asserted mid-operation; no stale result may appear after release.

Verification
REQ-030 SHALL pass, with defaults and out_ready=1: a=0x001000 (1.0), b=0x002000 (2.0) -> c=0x002000, overflow=0, transferred 3 edges after acceptance.
REQ-031 SHALL pass the negative and rounding cases: a=0xFFF000, b=0x003000 -> c=0xFFD000; a=0x000001, b=0x000800 -> c=0x000001 (tie rounds up).
REQ-032 SHALL pass the saturation cases: a=b=0x7FFFFF -> c=0x7FFFFF, overflow=1; a=0x800000, b=0x7FFFFF -> c=0x800000, overflow=1.
REQ-033 SHALL pass the backpressure case: out_ready=0 with in_valid=1 continuously -> exactly 3 pairs accepted, then in_ready=0 and c held stable; release out_ready -> 3 results in order, then one per cycle.
REQ-034 SHALL pass the bubble case: only stage LAT full and stalled, in_valid=1 -> the pair is accepted and in_ready stays 1 until all stages are full.
REQ-035 SHALL pass the reset case: rst pulsed with 2 pairs in flight -> out_valid=0 at once and no result ever emerges for those pairs.
